// File: rtl/ctrl_tx.sv
// Transmit side of the system controller: buffers RF and ALU result pulses and
// serializes them as bytes to the UART TX (ALU results go out LSB first).
module ctrl_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tx_rf_send,
  input  logic [DATA_WIDTH-1:0]     tx_rf_send_data,
  input  logic                      tx_alu_send,
  input  logic [2*DATA_WIDTH-1:0]   tx_alu_send_data,
  input  logic                      uart_tx_busy,
  output logic [DATA_WIDTH-1:0]     uart_tx_p_data,
  output logic                      uart_tx_d_vld,
  output logic                      ctrl_tx_busy,
  output logic                      ctrl_tx_ovf
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RF_SEND    = 3'd1,
    RF_WAIT    = 3'd2,
    ALU_L_SEND = 3'd3,
    ALU_L_WAIT = 3'd4,
    ALU_H_SEND = 3'd5,
    ALU_H_WAIT = 3'd6
  } state_t;

  state_t                    state_reg, state_next;
  logic [DATA_WIDTH-1:0]     rf_buf_reg;
  logic [2*DATA_WIDTH-1:0]   alu_buf_reg;
  logic                      rf_pend_reg, alu_pend_reg;
  logic                      ovf_reg;
  logic                      rf_done, alu_done;
  logic                      rf_accept, alu_accept;
  logic                      rf_drop, alu_drop;

  // A pulse arriving while its source's last byte completes is accepted: load wins over clear.
  assign rf_accept  = tx_rf_send  && (!rf_pend_reg  || rf_done);
  assign alu_accept = tx_alu_send && (!alu_pend_reg || alu_done);
  assign rf_drop    = tx_rf_send  && !rf_accept;
  assign alu_drop   = tx_alu_send && !alu_accept;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      rf_buf_reg   <= '0;
      alu_buf_reg  <= '0;
      rf_pend_reg  <= 1'b0;
      alu_pend_reg <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (rf_accept) begin
        rf_buf_reg  <= tx_rf_send_data;
        rf_pend_reg <= 1'b1;
      end else if (rf_done) begin
        rf_pend_reg <= 1'b0;
      end
      if (alu_accept) begin
        alu_buf_reg  <= tx_alu_send_data;
        alu_pend_reg <= 1'b1;
      end else if (alu_done) begin
        alu_pend_reg <= 1'b0;
      end
      if (rf_drop || alu_drop) begin
        ovf_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    uart_tx_d_vld  = 1'b0;
    uart_tx_p_data = '0;
    rf_done        = 1'b0;
    alu_done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!uart_tx_busy) begin
          if (rf_pend_reg) begin
            state_next = RF_SEND;
          end else if (alu_pend_reg) begin
            state_next = ALU_L_SEND;
          end
        end
      end
      RF_SEND: begin
        uart_tx_d_vld  = 1'b1;
        uart_tx_p_data = rf_buf_reg;
        if (uart_tx_busy) state_next = RF_WAIT;
      end
      RF_WAIT: begin
        if (!uart_tx_busy) begin
          state_next = IDLE;
          rf_done    = 1'b1;
        end
      end
      ALU_L_SEND: begin
        uart_tx_d_vld  = 1'b1;
        uart_tx_p_data = alu_buf_reg[DATA_WIDTH-1:0];
        if (uart_tx_busy) state_next = ALU_L_WAIT;
      end
      ALU_L_WAIT: begin
        if (!uart_tx_busy) state_next = ALU_H_SEND;
      end
      ALU_H_SEND: begin
        uart_tx_d_vld  = 1'b1;
        uart_tx_p_data = alu_buf_reg[2*DATA_WIDTH-1:DATA_WIDTH];
        if (uart_tx_busy) state_next = ALU_H_WAIT;
      end
      ALU_H_WAIT: begin
        if (!uart_tx_busy) begin
          state_next = IDLE;
          alu_done   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign ctrl_tx_busy = rf_pend_reg || alu_pend_reg || (state_reg != IDLE);
  assign ctrl_tx_ovf  = ovf_reg;

endmodule

// File: tb/tb_ctrl_tx.sv
// Bench for ctrl_tx: a UART TX model consumes bytes, a scoreboard queue holds the
// expected byte stream; table rows plus hand-written multi-cycle sequences.
module tb_ctrl_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tx_rf_send = 1'b0;
  logic [7:0]  tx_rf_send_data = '0;
  logic        tx_alu_send = 1'b0;
  logic [15:0] tx_alu_send_data = '0;
  logic        u_busy = 1'b0;
  logic [7:0]  uart_tx_p_data;
  logic        uart_tx_d_vld;
  logic        ctrl_tx_busy;
  logic        ctrl_tx_ovf;

  int          tests = 0;
  int          failed = 0;
  int          cap_cnt = 0;
  int          ucnt = 0;
  logic [7:0]  exp_q[$];

  ctrl_tx #(.DATA_WIDTH(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .tx_rf_send       (tx_rf_send),
    .tx_rf_send_data  (tx_rf_send_data),
    .tx_alu_send      (tx_alu_send),
    .tx_alu_send_data (tx_alu_send_data),
    .uart_tx_busy     (u_busy),
    .uart_tx_p_data   (uart_tx_p_data),
    .uart_tx_d_vld    (uart_tx_d_vld),
    .ctrl_tx_busy     (ctrl_tx_busy),
    .ctrl_tx_ovf      (ctrl_tx_ovf)
  );

  always #5 clk = ~clk;

  // UART TX model: takes a byte when free, busy from the next cycle for 10 cycles.
  always @(posedge clk) begin
    if (!u_busy && uart_tx_d_vld) begin
      u_busy <= 1'b1;
      ucnt   <= 10;
    end else if (u_busy) begin
      if (ucnt == 1) u_busy <= 1'b0;
      ucnt <= ucnt - 1;
    end
  end

  // Scoreboard: whatever the UART is about to take must match the queue head.
  always @(negedge clk) begin
    if (reset && uart_tx_d_vld && !u_busy) begin
      cap_cnt++;
      tests++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL unexpected_byte got=%02h want=none", uart_tx_p_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (uart_tx_p_data !== e) begin
          failed++;
          $display("FAIL byte_order got=%02h want=%02h", uart_tx_p_data, e);
        end else begin
          $display("[TB] byte %02h ok", uart_tx_p_data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      failed++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (exp_q.size() == 0 && !ctrl_tx_busy && !u_busy) done = 1'b1;
      else tick();
    end
    if (!done) begin
      tests++;
      failed++;
      $display("FAIL %s_timeout got=busy want=drained", name);
    end
  endtask

  task automatic wait_ubusy(input logic lvl, input string name);
    bit done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      if (u_busy == lvl) done = 1'b1;
      else tick();
    end
    if (!done) begin
      tests++;
      failed++;
      $display("FAIL %s_timeout got=%0b want=%0b", name, u_busy, lvl);
    end
  endtask

  typedef struct {
    logic            rf_en;
    logic [7:0]      rf_data;
    logic            alu_en;
    logic [15:0]     alu_data;
    int              n_bytes;
    logic [2:0][7:0] bytes;
    logic            exp_ovf;
  } vec_t;

  function automatic vec_t mk(input logic rfe, input logic [7:0] rfd, input logic ae,
                              input logic [15:0] ad, input int n,
                              input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    vec_t v;
    v.rf_en = rfe; v.rf_data = rfd; v.alu_en = ae; v.alu_data = ad;
    v.n_bytes = n; v.bytes = {b2, b1, b0}; v.exp_ovf = 1'b0;
    return v;
  endfunction

  vec_t vecs [6];

  initial begin
    int c0;
    vecs[0] = mk(1'b1, 8'h5A, 1'b0, 16'h0000, 1, 8'h5A, 8'h00, 8'h00);
    vecs[1] = mk(1'b0, 8'h00, 1'b1, 16'hBEEF, 2, 8'hEF, 8'hBE, 8'h00);
    vecs[2] = mk(1'b1, 8'h11, 1'b1, 16'h2233, 3, 8'h11, 8'h33, 8'h22);
    vecs[3] = mk(1'b1, 8'h00, 1'b0, 16'h0000, 1, 8'h00, 8'h00, 8'h00);
    vecs[4] = mk(1'b0, 8'h00, 1'b1, 16'hFF00, 2, 8'h00, 8'hFF, 8'h00);
    vecs[5] = mk(1'b1, 8'hFF, 1'b1, 16'h0180, 3, 8'hFF, 8'h80, 8'h01);

    // Reset state
    repeat (3) tick();
    check("rst_d_vld", 32'(uart_tx_d_vld), 0);
    check("rst_p_data", 32'(uart_tx_p_data), 0);
    check("rst_busy", 32'(ctrl_tx_busy), 0);
    check("rst_ovf", 32'(ctrl_tx_ovf), 0);
    reset = 1'b1;
    repeat (2) tick();

    // Test 1: latency N+2 and ctrl_tx_busy falling after the UART frees up
    tx_rf_send = 1'b1; tx_rf_send_data = 8'h5A; exp_q.push_back(8'h5A);
    tick();
    tx_rf_send = 1'b0;
    check("lat_n1_d_vld", 32'(uart_tx_d_vld), 0);
    check("lat_n1_busy", 32'(ctrl_tx_busy), 1);
    tick();
    check("lat_n2_d_vld", 32'(uart_tx_d_vld), 1);
    check("lat_n2_p_data", 32'(uart_tx_p_data), 32'h5A);
    wait_ubusy(1'b1, "t1_rise");
    wait_ubusy(1'b0, "t1_fall");
    check("t1_busy_at_fall", 32'(ctrl_tx_busy), 1);
    tick();
    check("t1_busy_after", 32'(ctrl_tx_busy), 0);
    $display("[TB] test1 rf latency done");

    // Table-driven single transactions
    for (int i = 0; i < 6; i++) begin
      c0 = cap_cnt;
      tx_rf_send = vecs[i].rf_en;  tx_rf_send_data  = vecs[i].rf_data;
      tx_alu_send = vecs[i].alu_en; tx_alu_send_data = vecs[i].alu_data;
      for (int b = 0; b < vecs[i].n_bytes; b++) exp_q.push_back(vecs[i].bytes[b]);
      tick();
      tx_rf_send = 1'b0; tx_alu_send = 1'b0;
      wait_drain("vec");
      check("vec_nbytes", 32'(cap_cnt - c0), 32'(vecs[i].n_bytes));
      check("vec_ovf", 32'(ctrl_tx_ovf), 32'(vecs[i].exp_ovf));
      $display("[TB] vector %0d done: %0d bytes", i, cap_cnt - c0);
    end

    // Test 5: RF pulse in the cycle RF_WAIT exits is accepted
    tx_rf_send = 1'b1; tx_rf_send_data = 8'h33; exp_q.push_back(8'h33);
    tick();
    tx_rf_send = 1'b0;
    wait_ubusy(1'b1, "t5_rise");
    wait_ubusy(1'b0, "t5_fall");
    tx_rf_send = 1'b1; tx_rf_send_data = 8'h44; exp_q.push_back(8'h44);
    tick();
    tx_rf_send = 1'b0;
    check("t5_pend_kept", 32'(ctrl_tx_busy), 1);
    wait_drain("t5");
    check("t5_ovf", 32'(ctrl_tx_ovf), 0);
    $display("[TB] test5 accept-on-exit done");

    // Test 4: second RF pulse during RF_SEND is dropped, ovf sticky
    c0 = cap_cnt;
    tx_rf_send = 1'b1; tx_rf_send_data = 8'h11; exp_q.push_back(8'h11);
    tick();
    tx_rf_send = 1'b0;
    tick();
    check("t4_in_send", 32'(uart_tx_d_vld), 1);
    tx_rf_send = 1'b1; tx_rf_send_data = 8'h77;
    tick();
    tx_rf_send = 1'b0;
    check("t4_ovf_set", 32'(ctrl_tx_ovf), 1);
    check("t4_p_data_held", 32'(uart_tx_p_data), 32'h11);
    wait_drain("t4");
    check("t4_one_byte", 32'(cap_cnt - c0), 1);
    check("t4_ovf_sticky", 32'(ctrl_tx_ovf), 1);
    $display("[TB] test4 overflow done");

    // Test 6: reset during ALU_H_WAIT with an RF byte pending
    c0 = cap_cnt;
    tx_alu_send = 1'b1; tx_alu_send_data = 16'hCAFE;
    exp_q.push_back(8'hFE); exp_q.push_back(8'hCA);
    tick();
    tx_alu_send = 1'b0;
    for (int i = 0; i < 100 && cap_cnt != c0 + 2; i++) tick();
    check("t6_two_bytes", 32'(cap_cnt - c0), 2);
    repeat (3) tick();
    tx_rf_send = 1'b1; tx_rf_send_data = 8'h99;
    tick();
    tx_rf_send = 1'b0;
    reset = 1'b0;
    #1;
    check("t6_rst_d_vld", 32'(uart_tx_d_vld), 0);
    check("t6_rst_p_data", 32'(uart_tx_p_data), 0);
    check("t6_rst_busy", 32'(ctrl_tx_busy), 0);
    check("t6_rst_ovf", 32'(ctrl_tx_ovf), 0);
    repeat (2) tick();
    reset = 1'b1;
    c0 = cap_cnt;
    repeat (40) tick();
    check("t6_no_bytes", 32'(cap_cnt - c0), 0);
    check("t6_idle_busy", 32'(ctrl_tx_busy), 0);
    check("t6_queue_empty", 32'(exp_q.size()), 0);
    $display("[TB] test6 reset mid-op done");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
